// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice(input int width, input int digit);
        return width / digit;
    endfunction

    // One extra bit so the slice count can reach nslice itself.
    function automatic int slice_w(input int width, input int digit);
        return $clog2(nslice(width, digit)) + 1;
    endfunction

    localparam int SLICE_W = slice_w(16, 4);

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Start/ready/done handshake and result bundle of the serial comparator.
interface serial_magnitude_comparator_if
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) ();

    logic                              start;
    logic                              signed_mode;
    logic [WIDTH-1:0]                  a;
    logic [WIDTH-1:0]                  b;
    logic                              ready;
    logic                              done;
    logic                              gt;
    logic                              lt;
    logic                              eq;
    logic [slice_w(WIDTH, DIGIT)-1:0]  slices;

    modport master (
        output start, signed_mode, a, b,
        input  ready, done, gt, lt, eq, slices
    );

    modport slave (
        input  start, signed_mode, a, b,
        output ready, done, gt, lt, eq, slices
    );

endinterface

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational DIGIT-bit unsigned compare built as an MSB-first equality chain.
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             dgt,
    output logic             dlt
);

    logic [DIGIT:1]   eq_chain_s;
    logic [DIGIT-1:0] gt_bit_s;
    logic [DIGIT-1:0] lt_bit_s;

    assign eq_chain_s[DIGIT] = 1'b1;

    // Bit i decides only when every more-significant bit matched.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        if (i > 0) begin : g_chain
            assign eq_chain_s[i] = eq_chain_s[i+1] & ~(a[i] ^ b[i]);
        end
        assign gt_bit_s[i] = eq_chain_s[i+1] &  a[i] & ~b[i];
        assign lt_bit_s[i] = eq_chain_s[i+1] & ~a[i] &  b[i];
    end

    assign dgt = |gt_bit_s;
    assign dlt = |lt_bit_s;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial, MSB-first magnitude comparator with early exit and signed mode.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    serial_magnitude_comparator_if.slave   bus
);

    localparam int NSLICE = nslice(WIDTH, DIGIT);
    localparam int CNT_W  = slice_w(WIDTH, DIGIT);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    state_e             state_r;
    state_e             state_n;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   slices_r;
    logic               gt_r;
    logic               lt_r;
    logic               eq_r;
    logic               ready_r;
    logic               done_r;
    logic               dgt_s;
    logic               dlt_s;
    logic               top_eq_s;
    logic               last_s;

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .a   (a_sh_r[WIDTH-1 -: DIGIT]),
        .b   (b_sh_r[WIDTH-1 -: DIGIT]),
        .dgt (dgt_s),
        .dlt (dlt_s)
    );

    assign top_eq_s = ~(dgt_s | dlt_s);
    assign last_s   = (cnt_r == {CNT_W{1'b0}});

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_n = CMP;
                else           state_n = IDLE;
            end
            CMP: begin
                if (!top_eq_s || last_s) state_n = DONE;
                else                     state_n = CMP;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register with ready/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            ready_r <= (state_n == IDLE);
            done_r  <= (state_n == DONE);
        end
    end

    // Operand shifters, slice counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            slices_r <= {CNT_W{1'b0}};
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            eq_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        // Offset-binary mapping turns the signed compare into an unsigned one.
                        a_sh_r   <= bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
                        b_sh_r   <= bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
                        cnt_r    <= CNT_W'(NSLICE - 1);
                        slices_r <= {CNT_W{1'b0}};
                        gt_r     <= 1'b0;
                        lt_r     <= 1'b0;
                        eq_r     <= 1'b0;
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                CMP: begin
                    slices_r <= slices_r + CNT_W'(1);
                    if (!top_eq_s) begin
                        gt_r <= dgt_s;
                        lt_r <= dlt_s;
                    end else if (last_s) begin
                        eq_r <= 1'b1;
                    end else begin
                        a_sh_r <= a_sh_r << DIGIT;
                        b_sh_r <= b_sh_r << DIGIT;
                        cnt_r  <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.done   = done_r;
    assign bus.gt     = gt_r;
    assign bus.lt     = lt_r;
    assign bus.eq     = eq_r;
    assign bus.slices = slices_r;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: directed table, handshake corner cases, random and 4-bit sweeps.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator_if #(.WIDTH(16), .DIGIT(4)) bus16 ();
    serial_magnitude_comparator_if #(.WIDTH(4),  .DIGIT(1)) bus41 ();
    serial_magnitude_comparator_if #(.WIDTH(4),  .DIGIT(4)) bus44 ();

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    serial_magnitude_comparator #(.WIDTH(4),  .DIGIT(1)) dut41 (.clk(clk), .rst_n(rst_n), .bus(bus41));
    serial_magnitude_comparator #(.WIDTH(4),  .DIGIT(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        g;
        logic        l;
        logic        e;
        int          sl;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: integer compare after optional sign interpretation; k = first differing digit + 1.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input int w, input int d,
                                  input logic m, output logic g, output logic l, output logic e,
                                  output int k);
        longint ua, ub, va, vb;
        int     ns;
        logic   found;
        ua = longint'(a) % (longint'(1) << w);
        ub = longint'(b) % (longint'(1) << w);
        va = ua;
        vb = ub;
        if (m && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
        if (m && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
        g = (va > vb);
        l = (va < vb);
        e = (va == vb);
        ns = w / d;
        k = ns;
        found = 1'b0;
        for (int i = 0; i < ns; i++) begin
            if (!found && (((ua >> (w - d * (i + 1))) % (longint'(1) << d)) !=
                           ((ub >> (w - d * (i + 1))) % (longint'(1) << d)))) begin
                k = i + 1;
                found = 1'b1;
            end
        end
    endfunction

    task automatic wait_ready16();
        int guard = 0;
        @(negedge clk);
        while (!bus16.ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!bus16.ready) check("ready_wait16", 32'd0, 32'd1);
    endtask

    task automatic cmp16(input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic g, output logic l, output logic e, output int sl, output int lat);
        wait_ready16();
        bus16.a = a;
        bus16.b = b;
        bus16.signed_mode = m;
        bus16.start = 1'b1;
        @(posedge clk);
        #1 bus16.start = 1'b0;
        lat = 0; g = 1'b0; l = 1'b0; e = 1'b0; sl = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus16.done) begin
                lat = c; g = bus16.gt; l = bus16.lt; e = bus16.eq; sl = int'(bus16.slices);
                break;
            end
        end
        if (lat == 0) check("done_timeout16", 32'd0, 32'd1);
    endtask

    task automatic sweep4();
        logic g, l, e, g41, l41, e41, g44, l44, e44;
        int   k41, k44, s41, s44, lat41, lat44, guard;
        for (int m = 0; m < 2; m++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    guard = 0;
                    @(negedge clk);
                    while (!(bus41.ready && bus44.ready) && guard < 20) begin
                        @(negedge clk);
                        guard++;
                    end
                    bus41.a = 4'(ia); bus41.b = 4'(ib); bus41.signed_mode = m[0]; bus41.start = 1'b1;
                    bus44.a = 4'(ia); bus44.b = 4'(ib); bus44.signed_mode = m[0]; bus44.start = 1'b1;
                    @(posedge clk);
                    #1;
                    bus41.start = 1'b0;
                    bus44.start = 1'b0;
                    lat41 = 0; lat44 = 0;
                    g41 = 0; l41 = 0; e41 = 0; s41 = 0; g44 = 0; l44 = 0; e44 = 0; s44 = 0;
                    for (int c = 1; c <= 12; c++) begin
                        @(posedge clk);
                        @(negedge clk);
                        if (bus41.done && lat41 == 0) begin
                            lat41 = c; g41 = bus41.gt; l41 = bus41.lt; e41 = bus41.eq; s41 = int'(bus41.slices);
                        end
                        if (bus44.done && lat44 == 0) begin
                            lat44 = c; g44 = bus44.gt; l44 = bus44.lt; e44 = bus44.eq; s44 = int'(bus44.slices);
                        end
                        if (lat41 != 0 && lat44 != 0) break;
                    end
                    model(16'(ia), 16'(ib), 4, 1, m[0], g, l, e, k41);
                    model(16'(ia), 16'(ib), 4, 4, m[0], g, l, e, k44);
                    check("sw41_res", {29'd0, g41, l41, e41}, {29'd0, g, l, e});
                    check("sw41_onehot", 32'(g41 + l41 + e41), 32'd1);
                    check("sw41_range", 32'((s41 >= 1) && (s41 <= 4)), 32'd1);
                    check("sw41_slices", 32'(s41), 32'(k41));
                    check("sw41_lat", 32'(lat41), 32'(k41));
                    check("sw44_res", {29'd0, g44, l44, e44}, {29'd0, g, l, e});
                    check("sw44_onehot", 32'(g44 + l44 + e44), 32'd1);
                    check("sw44_slices", 32'(s44), 32'(k44));
                    check("sw44_lat", 32'(lat44), 32'd1);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g, l, e, eg, el, ee;
        logic [15:0] ra, rb;
        logic        rm;
        int          sl, lat, k, ndone;

        vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        vecs[1] = '{16'h9000, 16'h1FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{16'h9000, 16'h1FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{16'h00A5, 16'h00A6, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[4] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[5] = '{16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 4};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[7] = '{16'h1200, 16'h1300, 1'b0, 1'b0, 1'b1, 1'b0, 2};

        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a = 16'd0; bus16.b = 16'd0;
        bus41.start = 1'b0; bus41.signed_mode = 1'b0; bus41.a = 4'd0;  bus41.b = 4'd0;
        bus44.start = 1'b0; bus44.signed_mode = 1'b0; bus44.a = 4'd0;  bus44.b = 4'd0;

        #12;
        check("rst_ready", 32'(bus16.ready), 32'd1);
        check("rst_done", 32'(bus16.done), 32'd0);
        check("rst_res", {29'd0, bus16.gt, bus16.lt, bus16.eq}, 32'd0);
        check("rst_slices", 32'(bus16.slices), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cmp16(vecs[i].a, vecs[i].b, vecs[i].m, g, l, e, sl, lat);
            check($sformatf("vec%0d_res", i), {29'd0, g, l, e}, {29'd0, vecs[i].g, vecs[i].l, vecs[i].e});
            check($sformatf("vec%0d_slices", i), 32'(sl), 32'(vecs[i].sl));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].sl));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus16.done), 32'd0);
            check($sformatf("vec%0d_ready_back", i), 32'(bus16.ready), 32'd1);
        end

        // Busy start: second request while comparing must be dropped.
        wait_ready16();
        bus16.a = 16'h0001; bus16.b = 16'h0002; bus16.signed_mode = 1'b0; bus16.start = 1'b1;
        @(posedge clk);
        #1 bus16.a = 16'hFFFF; bus16.b = 16'h0000;
        @(posedge clk);
        #1 bus16.start = 1'b0;
        ndone = 0; g = 0; l = 0; e = 0; sl = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus16.done) begin
                ndone++; g = bus16.gt; l = bus16.lt; e = bus16.eq; sl = int'(bus16.slices);
            end
        end
        check("busy_ndone", 32'(ndone), 32'd1);
        check("busy_res", {29'd0, g, l, e}, 32'b010);
        check("busy_slices", 32'(sl), 32'd4);

        // Reset in the middle of a compare.
        wait_ready16();
        bus16.a = 16'h0001; bus16.b = 16'h0002; bus16.signed_mode = 1'b0; bus16.start = 1'b1;
        @(posedge clk);
        #1 bus16.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midcmp_busy", 32'(bus16.ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus16.ready), 32'd1);
        check("midrst_done", 32'(bus16.done), 32'd0);
        check("midrst_res", {29'd0, bus16.gt, bus16.lt, bus16.eq}, 32'd0);
        check("midrst_slices", 32'(bus16.slices), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus16.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_idle", 32'(bus16.ready), 32'd1);

        // Random compares, half sharing a common prefix to reach later digits.
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rb = ra ^ 16'(16'($urandom) >> $urandom_range(0, 15));
            else                           rb = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            model(ra, rb, 16, 4, rm, eg, el, ee, k);
            cmp16(ra, rb, rm, g, l, e, sl, lat);
            check("rnd_res", {29'd0, g, l, e}, {29'd0, eg, el, ee});
            check("rnd_slices", 32'(sl), 32'(k));
            check("rnd_lat", 32'(lat), 32'(k));
        end

        sweep4();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
